// File: rtl/smc_pkg.sv
// Shared SCCB target definitions: FSM state encoding, phase geometry and the
// 3-sample majority helper used by the optional line glitch filter.
package smc_pkg;

  localparam int PHASE_LEN = 9;  // 8 data bits + 1 ACK/NA bit
  localparam int BIT_CNT_W = 4;

  typedef enum logic [3:0] {
    IDLE,
    ID,
    ID_X,
    SUB,
    SUB_X,
    WDAT,
    WDAT_X,
    RDAT,
    RDAT_NA,
    IGNORE
  } smc_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/sccb_tgt_line_mon.sv
// SIO_C/SIO_D synchroniser, optional majority filter (SCCB_TGT_GLITCH_FILTER_EN)
// and SCL edge / START / STOP detector. All outputs are clk-domain.
module sccb_tgt_line_mon
  import smc_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic sio_c_i,
  input  logic sio_d_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda
);

  logic [1:0] c_sync, d_sync;
  logic       scl;
  logic       scl_q, sda_q;

  // Synchronisers reset to 1 so an idle bus produces no edges after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_sync <= 2'b11;
      d_sync <= 2'b11;
    end else begin
      c_sync <= {c_sync[0], sio_c_i};
      d_sync <= {d_sync[0], sio_d_i};
    end
  end

`ifdef SCCB_TGT_GLITCH_FILTER_EN
  logic [1:0] c_hist, d_hist;
  logic       c_filt, d_filt;

  // Majority of the current and two previous samples; a 1-clk pulse never wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_hist <= 2'b11;
      d_hist <= 2'b11;
      c_filt <= 1'b1;
      d_filt <= 1'b1;
    end else begin
      c_hist <= {c_hist[0], c_sync[1]};
      d_hist <= {d_hist[0], d_sync[1]};
      c_filt <= maj3(c_sync[1], c_hist[0], c_hist[1]);
      d_filt <= maj3(d_sync[1], d_hist[0], d_hist[1]);
    end
  end

  assign scl = c_filt;
  assign sda = d_filt;
`else
  assign scl = c_sync[1];
  assign sda = d_sync[1];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl;
      sda_q <= sda;
    end
  end

  assign scl_rise  = scl & ~scl_q;
  assign scl_fall  = ~scl & scl_q;
  assign start_det = scl & scl_q & sda_q & ~sda;
  assign stop_det  = scl & scl_q & ~sda_q & sda;

endmodule

// File: rtl/sccb_target.sv
// SCCB (3-wire-compatible 2-wire) register target: ID / sub-address / data
// phases with burst write and sequential read. Optional SIO line glitch filter
// is enabled by defining SCCB_TGT_GLITCH_FILTER_EN.
module sccb_target
  import smc_pkg::*;
#(
  parameter logic [6:0] SLAVE_ID = 7'h21,
  parameter int         DATA_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sio_c_i,
  input  logic              sio_d_i,
  output logic              sio_d_oe_o,
  output logic [DATA_W-1:0] reg_addr_o,
  output logic [DATA_W-1:0] reg_wdata_o,
  output logic              reg_wr_o,
  output logic              reg_rd_o,
  input  logic [DATA_W-1:0] reg_rdata_i,
  output logic              busy_o,
  output smc_state_e        dbg_state
);

  localparam logic [BIT_CNT_W-1:0] LAST_DATA = BIT_CNT_W'(PHASE_LEN - 2);
  localparam logic [BIT_CNT_W-1:0] ACK_BIT   = BIT_CNT_W'(PHASE_LEN - 1);

  logic scl_rise, scl_fall, start_det, stop_det, sda;

  sccb_tgt_line_mon u_line_mon (
    .clk       (clk),
    .rst       (rst),
    .sio_c_i   (sio_c_i),
    .sio_d_i   (sio_d_i),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda       (sda)
  );

  smc_state_e           state;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [DATA_W-2:0]    rx;
  logic [DATA_W-1:0]    rx_next;
  logic [DATA_W-1:0]    tx;
  logic                 rd_mode;
  logic                 rd_pend;

  assign rx_next   = {rx, sda};
  assign dbg_state = state;

  // Register-side handshake: reg_wr_o is a 1-clk strobe with reg_addr_o and
  // reg_wdata_o valid in that clk; reg_rd_o is a 1-clk request with reg_addr_o
  // valid, and reg_rdata_i must be valid during the clk that follows it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      rx          <= '0;
      tx          <= '0;
      rd_mode     <= 1'b0;
      rd_pend     <= 1'b0;
      sio_d_oe_o  <= 1'b0;
      reg_addr_o  <= '0;
      reg_wdata_o <= '0;
      reg_wr_o    <= 1'b0;
      reg_rd_o    <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      reg_wr_o <= 1'b0;
      reg_rd_o <= 1'b0;
      rd_pend  <= reg_rd_o;
      if (rd_pend) tx <= reg_rdata_i;

      if (stop_det) begin
        state      <= IDLE;
        bit_cnt    <= '0;
        sio_d_oe_o <= 1'b0;
        busy_o     <= 1'b0;
      end else if (start_det) begin
        state      <= ID;
        bit_cnt    <= '0;
        sio_d_oe_o <= 1'b0;
        busy_o     <= 1'b1;
      end else begin
        case (state)
          ID, SUB, WDAT: begin
            if (scl_rise) begin
              rx <= rx_next[DATA_W-2:0];
              if (bit_cnt == LAST_DATA) begin
                bit_cnt <= ACK_BIT;
                case (state)
                  ID: begin
                    if (rx_next[7:1] == SLAVE_ID) begin
                      state    <= ID_X;
                      rd_mode  <= rx_next[0];
                      reg_rd_o <= rx_next[0];
                    end else begin
                      state <= IGNORE;
                    end
                  end
                  SUB: begin
                    reg_addr_o <= rx_next;
                    state      <= SUB_X;
                  end
                  default: begin
                    reg_wdata_o <= rx_next;
                    reg_wr_o    <= 1'b1;
                    state       <= WDAT_X;
                  end
                endcase
              end else begin
                bit_cnt <= bit_cnt + BIT_CNT_W'(1);
              end
            end
          end

          // ACK is held from the fall after bit 8 until the fall after bit 9.
          ID_X, SUB_X, WDAT_X: begin
            if (scl_rise && bit_cnt == ACK_BIT) bit_cnt <= '0;
            if (scl_fall) begin
              if (bit_cnt == ACK_BIT) begin
                sio_d_oe_o <= 1'b1;
              end else begin
                case (state)
                  ID_X: begin
                    if (rd_mode) begin
                      state      <= RDAT;
                      sio_d_oe_o <= ~tx[DATA_W-1];
                      tx         <= {tx[DATA_W-2:0], 1'b0};
                    end else begin
                      state      <= SUB;
                      sio_d_oe_o <= 1'b0;
                    end
                  end
                  SUB_X: begin
                    state      <= WDAT;
                    sio_d_oe_o <= 1'b0;
                  end
                  default: begin
                    state      <= WDAT;
                    sio_d_oe_o <= 1'b0;
                    reg_addr_o <= reg_addr_o + DATA_W'(1);
                  end
                endcase
              end
            end
          end

          RDAT: begin
            if (scl_fall) begin
              sio_d_oe_o <= ~tx[DATA_W-1];
              tx         <= {tx[DATA_W-2:0], 1'b0};
            end
            if (scl_rise) begin
              if (bit_cnt == LAST_DATA) begin
                bit_cnt <= ACK_BIT;
                state   <= RDAT_NA;
              end else begin
                bit_cnt <= bit_cnt + BIT_CNT_W'(1);
              end
            end
          end

          RDAT_NA: begin
            if (scl_fall) sio_d_oe_o <= 1'b0;
            if (scl_rise) begin
              bit_cnt <= '0;
              if (!sda) begin
                reg_addr_o <= reg_addr_o + DATA_W'(1);
                reg_rd_o   <= 1'b1;
                state      <= RDAT;
              end else begin
                state <= IGNORE;
              end
            end
          end

          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sccb_target.sv
// Self-checking bench for sccb_target: bus-level master tasks, a register-file
// responder and a reference model of the target's address/data behaviour.
module tb_sccb_target;
  import smc_pkg::*;

  localparam int QCLK = 8;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       scl   = 1'b1;
  logic       m_sda = 1'b1;
  logic       sio_d;
  logic       sio_d_oe_o;
  logic [7:0] reg_addr_o, reg_wdata_o, reg_rdata_i;
  logic       reg_wr_o, reg_rd_o, busy_o;
  smc_state_e dbg_state;

  int errors = 0;
  int checks = 0;

  logic [7:0]  rf[256];
  logic [7:0]  ref_mem[256];
  logic [7:0]  m_addr;
  logic [15:0] exp_q[$];
  logic [15:0] wr_log[$];
  int          rd_cnt;
  logic        oe_seen;

  always #5 clk = ~clk;

  assign sio_d       = m_sda & ~sio_d_oe_o;
  assign reg_rdata_i = rf[reg_addr_o];

  sccb_target #(.SLAVE_ID(7'h21), .DATA_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .sio_c_i     (scl),
    .sio_d_i     (sio_d),
    .sio_d_oe_o  (sio_d_oe_o),
    .reg_addr_o  (reg_addr_o),
    .reg_wdata_o (reg_wdata_o),
    .reg_wr_o    (reg_wr_o),
    .reg_rd_o    (reg_rd_o),
    .reg_rdata_i (reg_rdata_i),
    .busy_o      (busy_o),
    .dbg_state   (dbg_state)
  );

  // Register-file side and bus activity monitor, sampled away from posedge.
  always @(negedge clk) begin
    if (!rst) begin
      if (reg_wr_o) begin
        wr_log.push_back({reg_addr_o, reg_wdata_o});
        rf[reg_addr_o] = reg_wdata_o;
      end
      if (reg_rd_o) rd_cnt++;
      if (sio_d_oe_o) oe_seen = 1'b1;
    end
  end

  // ---------------- bus master driver tasks ----------------
  task automatic q();
    repeat (QCLK) @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    m_sda = 1'b1; q();
    scl = 1'b1;   q();
    m_sda = 1'b0; q();
    scl = 1'b0;   q();
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; q();
    scl = 1'b1;   q();
    m_sda = 1'b1; q();
  endtask

  task automatic bus_bit(input logic b, output logic s, output logic oe);
    m_sda = b; q();
    scl = 1'b1; q();
    s  = sio_d;
    oe = sio_d_oe_o;
    q();
    scl = 1'b0; q();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s, oe;
    for (int i = 7; i >= 0; i--) bus_bit(b[i], s, oe);
    bus_bit(1'b1, s, oe);
    ack = oe & ~s;
  endtask

  task automatic read_byte(input logic na, output logic [7:0] d);
    logic s, oe;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, s, oe);
      d[i] = s;
    end
    bus_bit(na, s, oe);
  endtask

  // ---------------- reference model ----------------
  task automatic model_write(input logic [7:0] d);
    ref_mem[m_addr] = d;
    exp_q.push_back({m_addr, d});
    m_addr = m_addr + 8'd1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; scl = 1'b1; m_sda = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (sio_d_oe_o !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b want 0", sio_d_oe_o); end
    checks++; if (reg_wr_o !== 1'b0) begin errors++; $display("FAIL reset_wr: got %b want 0", reg_wr_o); end
    checks++; if (reg_rd_o !== 1'b0) begin errors++; $display("FAIL reset_rd: got %b want 0", reg_rd_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    checks++; if (reg_addr_o !== 8'h00) begin errors++; $display("FAIL reset_addr: got %h want 00", reg_addr_o); end
    checks++; if (reg_wdata_o !== 8'h00) begin errors++; $display("FAIL reset_wdata: got %h want 00", reg_wdata_o); end
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL reset_state: got %s want IDLE", dbg_state.name()); end
    @(posedge clk); #1;
    rst = 1'b0;
    m_addr = 8'h00;
    q();
  endtask

  task automatic test_write3();
    logic a0, a1, a2;
    logic [15:0] e, g;
    wr_log.delete(); exp_q.delete(); rd_cnt = 0;
    bus_start();
    send_byte(8'h42, a0);
    send_byte(8'h12, a1); m_addr = 8'h12;
    send_byte(8'h80, a2); model_write(8'h80);
    bus_stop();
    checks++; if ({a0, a1, a2} !== 3'b111) begin errors++; $display("FAIL w3_acks: got %b want 111", {a0, a1, a2}); end
    checks++; if (wr_log.size() !== exp_q.size()) begin errors++; $display("FAIL w3_wr_count: got %0d want %0d", wr_log.size(), exp_q.size()); end
    while (exp_q.size() > 0 && wr_log.size() > 0) begin
      e = exp_q.pop_front(); g = wr_log.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL w3_write: got addr/data %h want %h", g, e); end
    end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL w3_busy: got %b want 0", busy_o); end
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL w3_state: got %s want IDLE", dbg_state.name()); end
  endtask

  task automatic test_read2();
    logic a0, a1, a2;
    logic [7:0] d;
    rf[8'h0A] = 8'h76; ref_mem[8'h0A] = 8'h76;
    wr_log.delete(); rd_cnt = 0;
    bus_start();
    send_byte(8'h42, a0);
    send_byte(8'h0A, a1); m_addr = 8'h0A;
    bus_stop();
    checks++; if (wr_log.size() !== 0) begin errors++; $display("FAIL r2_no_write: got %0d strobes want 0", wr_log.size()); end
    checks++; if (reg_addr_o !== m_addr) begin errors++; $display("FAIL r2_addr: got %h want %h", reg_addr_o, m_addr); end
    bus_start();
    send_byte(8'h43, a2);
    read_byte(1'b1, d);
    bus_stop();
    checks++; if ({a0, a1, a2} !== 3'b111) begin errors++; $display("FAIL r2_acks: got %b want 111", {a0, a1, a2}); end
    checks++; if (d !== ref_mem[m_addr]) begin errors++; $display("FAIL r2_rdata: got %h want %h", d, ref_mem[m_addr]); end
    checks++; if (rd_cnt !== 1) begin errors++; $display("FAIL r2_rd_count: got %0d want 1", rd_cnt); end
  endtask

  task automatic test_id_mismatch();
    logic a0, a1, a2;
    logic b_mid;
    wr_log.delete(); rd_cnt = 0; oe_seen = 1'b0;
    bus_start();
    b_mid = busy_o;
    send_byte(8'h60, a0);
    send_byte(8'h11, a1);
    send_byte(8'h22, a2);
    bus_stop();
    checks++; if (b_mid !== 1'b1) begin errors++; $display("FAIL nid_busy_start: got %b want 1", b_mid); end
    checks++; if ({a0, a1, a2} !== 3'b000) begin errors++; $display("FAIL nid_acks: got %b want 000", {a0, a1, a2}); end
    checks++; if (oe_seen !== 1'b0) begin errors++; $display("FAIL nid_oe: got %b want 0", oe_seen); end
    checks++; if (wr_log.size() + rd_cnt !== 0) begin errors++; $display("FAIL nid_strobes: got %0d want 0", wr_log.size() + rd_cnt); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL nid_busy_stop: got %b want 0", busy_o); end
  endtask

  task automatic test_burst_wrap();
    logic a;
    logic ack_all;
    logic [7:0] dat[3];
    logic [15:0] e, g;
    dat[0] = 8'hA1; dat[1] = 8'hB2; dat[2] = 8'hC3;
    wr_log.delete(); exp_q.delete();
    ack_all = 1'b1;
    bus_start();
    send_byte(8'h42, a); ack_all &= a;
    send_byte(8'hFF, a); ack_all &= a; m_addr = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      send_byte(dat[k], a); ack_all &= a;
      model_write(dat[k]);
    end
    bus_stop();
    checks++; if (ack_all !== 1'b1) begin errors++; $display("FAIL burst_acks: got %b want 1", ack_all); end
    checks++; if (wr_log.size() !== 3) begin errors++; $display("FAIL burst_count: got %0d want 3", wr_log.size()); end
    while (exp_q.size() > 0 && wr_log.size() > 0) begin
      e = exp_q.pop_front(); g = wr_log.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL burst_write: got addr/data %h want %h", g, e); end
    end
  endtask

  task automatic test_abort();
    logic a, s, oe, ok;
    wr_log.delete();
    bus_start();
    send_byte(8'h42, a);
    send_byte(8'h30, a); m_addr = 8'h30;
    bus_bit(1'b1, s, oe); bus_bit(1'b0, s, oe); bus_bit(1'b1, s, oe); bus_bit(1'b1, s, oe);
    bus_stop();
    checks++; if (wr_log.size() !== 0) begin errors++; $display("FAIL abort_no_write: got %0d want 0", wr_log.size()); end
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL abort_state: got %s want IDLE", dbg_state.name()); end
    checks++; if (reg_addr_o !== m_addr) begin errors++; $display("FAIL abort_addr: got %h want %h", reg_addr_o, m_addr); end

    // Reset while the target is driving a read byte (bit 7 of 0x5A is 0).
    rf[8'h30] = 8'h5A; ref_mem[8'h30] = 8'h5A;
    bus_start();
    send_byte(8'h43, a);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (sio_d_oe_o === 1'b1) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rdrst_drive: got oe %b want 1 within 40 clk", sio_d_oe_o); end
    #2 rst = 1'b1;
    #1;
    checks++; if (sio_d_oe_o !== 1'b0) begin errors++; $display("FAIL rdrst_oe: got %b want 0", sio_d_oe_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rdrst_busy: got %b want 0", busy_o); end
    scl = 1'b1; m_sda = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    m_addr = 8'h00;
    q();
    checks++; if (reg_addr_o !== m_addr) begin errors++; $display("FAIL rdrst_addr: got %h want %h", reg_addr_o, m_addr); end
  endtask

  task automatic test_random();
    logic a, ack_all;
    logic [7:0] sub, d, expd;
    logic [15:0] e, g;
    int n;
    for (int it = 0; it < 3; it++) begin
      sub = 8'($urandom_range(0, 255));
      n   = $urandom_range(1, 3);
      wr_log.delete(); exp_q.delete(); rd_cnt = 0;
      ack_all = 1'b1;
      bus_start();
      send_byte(8'h42, a); ack_all &= a;
      send_byte(sub, a);   ack_all &= a; m_addr = sub;
      for (int k = 0; k < n; k++) begin
        d = 8'($urandom);
        send_byte(d, a); ack_all &= a;
        model_write(d);
      end
      bus_stop();
      checks++; if (wr_log.size() !== n) begin errors++; $display("FAIL rnd_wr_count: got %0d want %0d", wr_log.size(), n); end
      while (exp_q.size() > 0 && wr_log.size() > 0) begin
        e = exp_q.pop_front(); g = wr_log.pop_front();
        checks++; if (g !== e) begin errors++; $display("FAIL rnd_write: got addr/data %h want %h", g, e); end
      end
      bus_start();
      send_byte(8'h42, a); ack_all &= a;
      send_byte(sub, a);   ack_all &= a; m_addr = sub;
      bus_stop();
      bus_start();
      send_byte(8'h43, a); ack_all &= a;
      for (int k = 0; k < n; k++) begin
        read_byte(k == n - 1, d);
        expd = ref_mem[m_addr];
        checks++; if (d !== expd) begin errors++; $display("FAIL rnd_read: got %h want %h at %h", d, expd, m_addr); end
        if (k != n - 1) m_addr = m_addr + 8'd1;
      end
      bus_stop();
      checks++; if (ack_all !== 1'b1) begin errors++; $display("FAIL rnd_acks: got %b want 1", ack_all); end
      checks++; if (rd_cnt !== n) begin errors++; $display("FAIL rnd_rd_count: got %0d want %0d", rd_cnt, n); end
    end
  endtask

`ifdef SCCB_TGT_GLITCH_FILTER_EN
  task automatic test_glitch();
    logic a, s, oe, ack_all;
    logic [7:0] id;
    logic [15:0] e, g;
    smc_state_e st0;
    id = 8'h42;
    wr_log.delete(); exp_q.delete();
    ack_all = 1'b1;
    bus_start();
    for (int i = 7; i >= 5; i--) bus_bit(id[i], s, oe);
    st0 = dbg_state;
    @(posedge clk); #1 scl = 1'b1;
    @(posedge clk); #1 scl = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    checks++; if (dbg_state !== st0) begin errors++; $display("FAIL glitch_state: got %s want %s", dbg_state.name(), st0.name()); end
    for (int i = 4; i >= 0; i--) bus_bit(id[i], s, oe);
    bus_bit(1'b1, s, oe); ack_all &= oe & ~s;
    send_byte(8'h55, a); ack_all &= a; m_addr = 8'h55;
    send_byte(8'h99, a); ack_all &= a; model_write(8'h99);
    bus_stop();
    checks++; if (ack_all !== 1'b1) begin errors++; $display("FAIL glitch_acks: got %b want 1", ack_all); end
    checks++; if (wr_log.size() !== 1) begin errors++; $display("FAIL glitch_count: got %0d want 1", wr_log.size()); end
    while (exp_q.size() > 0 && wr_log.size() > 0) begin
      e = exp_q.pop_front(); g = wr_log.pop_front();
      checks++; if (g !== e) begin errors++; $display("FAIL glitch_write: got addr/data %h want %h", g, e); end
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) begin
      rf[i]      = 8'($urandom);
      ref_mem[i] = rf[i];
    end
    rd_cnt  = 0;
    oe_seen = 1'b0;
    test_reset();
    test_write3();
    test_read2();
    test_id_mismatch();
    test_burst_wrap();
    test_abort();
    test_random();
`ifdef SCCB_TGT_GLITCH_FILTER_EN
    test_glitch();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3_000_000;
    errors++;
    checks++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sccb_target.md
SCCB_TARGET -- requirements
Module: sccb_target

Interface
REQ-001 SHALL have parameter SLAVE_ID, default 7'h21, giving the 7-bit SCCB ID this target answers to.
REQ-002 SHALL have parameter DATA_W, default 8, giving the sub-address and data width.
REQ-003 SHALL have port clk, input, 1 bit: single system clock; all logic runs on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port sio_c_i, input, 1 bit: raw SCCB clock from the bus, asynchronous to clk.
REQ-006 SHALL have port sio_d_i, input, 1 bit: raw SCCB data from the bus, asynchronous to clk.
REQ-007 SHALL have port sio_d_oe_o, output, 1 bit: open-drain enable; 1 pulls SIO_D low, 0 releases it.
REQ-008 SHALL have port reg_addr_o, output, DATA_W bits: the latched sub-address.
REQ-009 SHALL have port reg_wdata_o, output, DATA_W bits: the write data byte.
REQ-010 SHALL have port reg_wr_o, output, 1 bit: one-clk write strobe.
REQ-011 SHALL have port reg_rd_o, output, 1 bit: one-clk read request.
REQ-012 SHALL have port reg_rdata_i, input, DATA_W bits: read data, valid in the clk after reg_rd_o.
REQ-013 SHALL have port busy_o, output, 1 bit: high from START detect until STOP or abort.

Function
REQ-014 SHALL synchronise sio_c_i and sio_d_i through 2 flops, then detect edges on the synchronised copies (scl_rise, scl_fall).
REQ-015 SHALL detect START when synchronised SIO_D falls while SIO_C is high, and STOP when SIO_D rises while SIO_C is high.
REQ-016 SHALL sample SIO_D on scl_rise, MSB first, using a 4-bit bit counter that wraps from 8 to 0 after each 9-bit phase.
REQ-017 SHALL implement the states IDLE, ID, ID_X, SUB, SUB_X, WDAT, WDAT_X, RDAT, RDAT_NA and IGNORE.
REQ-018 SHALL make START from any state enter ID with the bit counter cleared; a repeated START is legal.
REQ-019 SHALL make STOP from any state return to IDLE and release sio_d_oe_o within 1 clk.
REQ-020 SHALL, after 8 ID bits, go to ID_X if ID[7:1]==SLAVE_ID, else to IGNORE; IGNORE waits for START or STOP.
REQ-021 SHALL, in the X/ACK states (ID_X, SUB_X, WDAT_X), assert sio_d_oe_o from the scl_fall after bit 8 to the scl_fall after bit 9.
REQ-022 SHALL go from ID_X (write) to SUB, from SUB_X to WDAT, and from WDAT_X to WDAT with reg_addr_o incremented mod 2^DATA_W.
REQ-023 SHALL latch reg_addr_o at the end of SUB; a 2-phase write (ID, SUB, STOP) only updates reg_addr_o.
REQ-024 SHALL pulse reg_wr_o once, 1 clk after the 8th WDAT bit is sampled, with reg_wdata_o stable until the next strobe.
REQ-025 SHALL, for ID_X with the read bit set, pulse reg_rd_o on ID bit 8, load reg_rdata_i into a shift register on the next clk, and go to RDAT.
REQ-026 SHALL, in RDAT, drive sio_d_oe_o = ~shift[MSB] and update it on each scl_fall (first bit on the scl_fall ending ID_X).
REQ-027 SHALL release SIO_D in RDAT_NA; if NA is sampled 0, pulse reg_rd_o with address +1 and return to RDAT, else go to IGNORE.
REQ-028 SHALL hold reg_addr_o unchanged when STOP or START arrives in mid-byte, and SHALL issue no strobe for the partial byte.

Reset
REQ-029 SHALL, on rst, set state to IDLE; sio_d_oe_o, reg_wr_o, reg_rd_o and busy_o to 0; reg_addr_o and reg_wdata_o to 0; synchronisers to 1 (bus idle).
REQ-030 SHALL take effect on rst immediately and release synchronously; a transfer in progress is discarded.

Configuration
REQ-031 SHALL, with SCCB_TGT_GLITCH_FILTER_EN defined, pass each synchronised line through a 3-sample majority filter (2 extra clk latency).
REQ-032 SHALL, without SCCB_TGT_GLITCH_FILTER_EN, feed the 2-flop outputs straight to edge detection.

Structure
REQ-033 SHALL take the state enum, phase length (9) and bit-counter width from the shared package smc_pkg.
REQ-034 SHALL put the synchroniser, optional filter and edge/START/STOP detector in one sub-module, sccb_tgt_line_mon.

Verification
REQ-035 SHALL verify a 3-phase write: START, ID 0x42, sub 0x12, data 0x80, STOP -> one reg_wr_o with addr 0x12 and wdata 0x80; sio_d_oe_o=1 in each 9th bit.
REQ-036 SHALL verify a 2-phase write then 2-phase read: ID 0x42, sub 0x0A, STOP; ID 0x43 with reg_rdata_i=0x76 -> SIO_D carries 0x76 MSB-first and reg_rd_o pulses once.
REQ-037 SHALL verify an ID mismatch: ID 0x60 -> sio_d_oe_o stays 0 for the whole transfer with no strobes, and busy_o clears on STOP.
REQ-038 SHALL verify a burst write: sub 0xFF followed by 3 data bytes -> writes land at 0xFF, 0x00, 0x01 (wrap-around).
REQ-039 SHALL verify a mid-byte abort: STOP after 4 data bits -> no reg_wr_o, IDLE within 1 clk; then rst mid-read -> sio_d_oe_o goes to 0 immediately.
REQ-040 SHALL verify that, with SCCB_TGT_GLITCH_FILTER_EN defined, a 1-clk glitch on SIO_C produces no bit sample and no state change.
